// File: rtl/image_rx_loader.sv
// image_rx_loader: 8N1 UART receiver and frame assembler that loads the
// expected-class label and the flattened pixel image for the CNN input stage.
// Frame format on the wire: SYNC_BYTE, label, then IMAGE_SIZE^2 pixel bytes
// in row-major order. The completed frame is held under a valid/ack handshake.
module image_rx_loader #(
  parameter int         CLKS_PER_BIT = 10416,
  parameter int         IMAGE_SIZE   = 28,
  parameter int         PIXEL_DEPTH  = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        RxD,
  input  logic                                        image_ack,
  output logic [IMAGE_SIZE*IMAGE_SIZE*PIXEL_DEPTH-1:0] image,
  output logic [7:0]                                  label,
  output logic                                        image_valid,
  output logic                                        busy,
  output logic                                        frame_err,
  output logic                                        overrun
);

  localparam int NUM_PIX = IMAGE_SIZE * IMAGE_SIZE;
  localparam int CNT_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int CLK_W   = $clog2(CLKS_PER_BIT);

  localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {HUNT, LABEL, PIXELS, DONE} asm_state_t;

  rx_state_t  r_state, r_next;
  asm_state_t a_state, a_next;

  logic             rx_meta, rx_s;
  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             tick;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic [CNT_W-1:0] pix_cnt;

  // ---- stage: input synchronizer (idle level is high) ----
  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_s    <= rx_meta;
    end
  end

  // ---- stage: bit-level receiver ----
  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Receiver next-state: half-bit wait to centre on the start bit, then full bits.
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (!rx_s) r_next = R_START;
      R_START: if (tick)  r_next = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (tick && bit_cnt == 3'd7) r_next = R_STOP;
      R_STOP:  if (tick)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Receiver outputs: sample strobe, accepted byte and bad-stop-bit pulse.
  always_comb begin
    tick       = (r_state == R_START) ? (clk_cnt == HALF_LAST) : (clk_cnt == BIT_LAST);
    byte_valid = (r_state == R_STOP) && tick && rx_s;
    frame_err  = (r_state == R_STOP) && tick && !rx_s;
    byte_data  = shift_reg;
  end

  // Bit timing counter and data-bit counter; both restart from idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (r_state == R_IDLE || tick) clk_cnt <= '0;
      else                           clk_cnt <= clk_cnt + 1'b1;
      if (r_state == R_IDLE)             bit_cnt <= '0;
      else if (r_state == R_DATA && tick) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // LSB-first shift register; data path carries no reset.
  always_ff @(posedge clk) begin
    if (r_state == R_DATA && tick) shift_reg <= {rx_s, shift_reg[7:1]};
  end

  // ---- stage: frame assembler ----
  // Assembler state register.
  always_ff @(posedge clk) begin
    if (rst) a_state <= HUNT;
    else     a_state <= a_next;
  end

  // Assembler next-state: a stop-bit error aborts a frame in progress.
  always_comb begin
    a_next = a_state;
    unique case (a_state)
      HUNT:    if (byte_valid && byte_data == SYNC_BYTE) a_next = LABEL;
      LABEL:   if (frame_err) a_next = HUNT;
               else if (byte_valid) a_next = PIXELS;
      PIXELS:  if (frame_err) a_next = HUNT;
               else if (byte_valid && pix_cnt == PIX_LAST) a_next = DONE;
      DONE:    if (image_ack) a_next = HUNT;
      default: a_next = HUNT;
    endcase
  end

  // Assembler outputs decoded from state.
  always_comb begin
    image_valid = (a_state == DONE);
    busy        = (a_state == LABEL) || (a_state == PIXELS);
    overrun     = (a_state == DONE) && byte_valid;
  end

  // Pixel write pointer, cleared when the label arrives.
  always_ff @(posedge clk) begin
    if (rst)                                    pix_cnt <= '0;
    else if (a_state == LABEL && byte_valid)    pix_cnt <= '0;
    else if (a_state == PIXELS && byte_valid)   pix_cnt <= pix_cnt + 1'b1;
  end

  // Label and image registers; they hold until the next frame overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      label <= '0;
      image <= '0;
    end else begin
      if (a_state == LABEL && byte_valid) label <= byte_data;
      if (a_state == PIXELS && byte_valid)
        image[pix_cnt*PIXEL_DEPTH +: PIXEL_DEPTH] <= byte_data;
    end
  end

endmodule

// File: tb/tb_image_rx_loader.sv
// Testbench for image_rx_loader: directed UART frames with a queue-based
// scoreboard of expected label/image pairs. A 4x4 image keeps the run short.
module tb_image_rx_loader;

  localparam int CPB  = 16;
  localparam int ISZ  = 4;
  localparam int NPIX = ISZ * ISZ;
  localparam int IW   = NPIX * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RxD = 1'b1;
  logic          image_ack = 1'b0;
  logic [IW-1:0] image;
  logic [7:0]    label;
  logic          image_valid, busy, frame_err, overrun;

  image_rx_loader #(
    .CLKS_PER_BIT(CPB),
    .IMAGE_SIZE  (ISZ),
    .PIXEL_DEPTH (8),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RxD        (RxD),
    .image_ack  (image_ack),
    .image      (image),
    .label      (label),
    .image_valid(image_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    lbl;
    logic [IW-1:0] img;
  } frame_t;

  frame_t sb[$];
  int     errors = 0;
  int     checks = 0;

  // Pulse / edge counters observed at every rising edge.
  int   ferr_cnt = 0;
  int   ovr_cnt  = 0;
  int   vrise    = 0;
  logic v_q      = 1'b0;
  always @(posedge clk) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    v_q <= image_valid;
    if (image_valid && !v_q) vrise <= vrise + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    RxD = 1'b1;
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int p);
    case (mode)
      0:       return 8'(p % 256);
      1:       return 8'hA5;
      default: return 8'(p * 7 + 3);
    endcase
  endfunction

  // Send sync, label and all pixels back to back; queue the expected frame.
  task automatic send_frame(input logic [7:0] lbl, input int mode);
    frame_t f;
    f.lbl = lbl;
    f.img = '0;
    send_byte(8'hA5);
    send_byte(lbl);
    for (int p = 0; p < NPIX; p++) begin
      f.img[p*8 +: 8] = pix_val(mode, p);
      send_byte(pix_val(mode, p));
    end
    sb.push_back(f);
  endtask

  // Wait (bounded) for image_valid, then pop the scoreboard and compare.
  task automatic expect_frame(input string tag);
    frame_t f;
    int n = 0;
    while (!image_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, IW'(image_valid), IW'(1));
    if (sb.size() > 0) begin
      f = sb.pop_front();
      chk({tag, "_label"}, IW'(label), IW'(f.lbl));
      chk({tag, "_image"}, image, f.img);
    end else begin
      chk({tag, "_sb_empty"}, IW'(sb.size()), IW'(1));
    end
  endtask

  task automatic ack_frame();
    image_ack = 1'b1;
    @(negedge clk);
    image_ack = 1'b0;
  endtask

  initial begin
    int ferr0, ovr0, vr0;
    logic [IW-1:0] img_hold;
    logic [7:0]    lbl_hold;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_image", image, '0);
    chk("rst_label", IW'(label), IW'(0));
    chk("rst_valid", IW'(image_valid), IW'(0));
    chk("rst_busy", IW'(busy), IW'(0));
    chk("rst_ferr", IW'(frame_err), IW'(0));
    chk("rst_ovr", IW'(overrun), IW'(0));

    // 1: nominal frame
    send_frame(8'h07, 0);
    expect_frame("nom");
    chk("nom_pix0", IW'(image[7:0]), IW'(8'h00));
    chk("nom_pixlast", IW'(image[IW-1 -: 8]), IW'(8'h0F));
    chk("nom_busy", IW'(busy), IW'(0));
    ack_frame();
    chk("nom_ack_valid", IW'(image_valid), IW'(0));

    // 2: hunt past junk, sync value inside frame is data
    vr0 = vrise;
    send_byte(8'h3C);
    send_byte(8'hFF);
    chk("hunt_busy", IW'(busy), IW'(0));
    send_frame(8'h02, 1);
    expect_frame("insync");
    repeat (4) @(negedge clk);
    chk("insync_vrise", IW'(vrise - vr0), IW'(1));
    ack_frame();

    // 3: glitch rejected, bad stop bit aborts, next frame fine
    ferr0 = ferr_cnt;
    send_byte(8'hA5);
    send_byte(8'h03);
    for (int p = 0; p < 3; p++) send_byte(8'(p));
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_ferr", IW'(ferr_cnt - ferr0), IW'(0));
    chk("glitch_busy", IW'(busy), IW'(1));
    send_byte(8'h44, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("ferr_pulse", IW'(ferr_cnt - ferr0), IW'(1));
    chk("ferr_busy", IW'(busy), IW'(0));
    chk("ferr_valid", IW'(image_valid), IW'(0));
    send_frame(8'h5A, 2);
    expect_frame("after_ferr");

    // 4: overrun while holding the frame
    ovr0     = ovr_cnt;
    img_hold = image;
    lbl_hold = label;
    send_byte(8'h55);
    repeat (CPB) @(negedge clk);
    chk("ovr_pulse", IW'(ovr_cnt - ovr0), IW'(1));
    chk("ovr_valid", IW'(image_valid), IW'(1));
    chk("ovr_image", image, img_hold);
    chk("ovr_label", IW'(label), IW'(lbl_hold));
    ack_frame();
    chk("ovr_ack_valid", IW'(image_valid), IW'(0));

    // 5: reset mid-frame, ack ignored outside DONE
    send_byte(8'hA5);
    send_byte(8'h11);
    for (int p = 0; p < 10; p++) send_byte(8'hC0 + 8'(p));
    ack_frame();
    chk("ack_ignored_busy", IW'(busy), IW'(1));
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    RxD = 1'b1;
    chk("mrst_image", image, '0);
    chk("mrst_label", IW'(label), IW'(0));
    chk("mrst_valid", IW'(image_valid), IW'(0));
    chk("mrst_busy", IW'(busy), IW'(0));
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h09, 0);
    expect_frame("post_rst");
    ack_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
